// File: rtl/regfile_pkg.sv
// Shared widths, constants and request record for the register-file
// writeback arbiter.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Register 0 is hardwired; writes and claims to it are discarded.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle: two requesters, each valid/addr/data with a
// returned ready.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on the last grant when mode=1, otherwise
// fixed priority with req[0] winning. Grants are forced low during reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_gnt = 1 means requester 1 won most recently, so requester 0 is next
  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (mode && !last_gnt) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and load writeback
// paths, tracks outstanding destination registers and counts stall cycles.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  regfile_wb_arbiter_if.slave wb,
  input  logic                claim_valid,
  input  logic [ADDR_W-1:0]   claim_addr,
  output logic                RegWr,
  output logic [ADDR_W-1:0]   RW,
  output logic [DATA_W-1:0]   BusW,
  output logic [NREG-1:0]     busy,
  output logic [15:0]         stall_cnt
);

  logic [1:0]      req;
  logic [1:0]      gnt;
  wb_req_t         win;
  logic            win_write;
  logic            stall;
  logic [NREG-1:0] busy_next;

  assign req = {wb.req1_valid, wb.req0_valid};

  rr_arb2 u_arb (
    .clk   (Clk),
    .rst_n (Rst),
    .mode  (RR_EN),
    .req   (req),
    .gnt   (gnt)
  );

  assign wb.req0_ready = gnt[0];
  assign wb.req1_ready = gnt[1];

  always_comb begin
    win = '0;
    if (gnt[1]) begin
      win = '{valid: 1'b1, addr: wb.req1_addr, data: wb.req1_data};
    end else if (gnt[0]) begin
      win = '{valid: 1'b1, addr: wb.req0_addr, data: wb.req0_data};
    end
  end

  assign win_write = win.valid && !is_zero_reg(win.addr);
  assign stall     = (wb.req0_valid && !gnt[0]) || (wb.req1_valid && !gnt[1]);

  // Clear for the write on the port this cycle, then apply the claim so a
  // reservation landing on the same edge keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (RegWr) begin
      busy_next[RW] = 1'b0;
    end
    if (claim_valid && !is_zero_reg(claim_addr)) begin
      busy_next[claim_addr] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      RegWr     <= 1'b0;
      RW        <= '0;
      BusW      <= '0;
      busy      <= '0;
      stall_cnt <= '0;
    end else begin
      RegWr <= win_write;
      if (win_write) begin
        RW   <= win.addr;
        BusW <= win.data;
      end
      busy <= busy_next;
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
